// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/operand/result bundle between control unit and mult_div_unit
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiply / restoring divide owning HI and LO
module mult_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     addend, sum, trial;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvsr_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        sgn_a    = ~bus.op[0] & bus.a[WIDTH-1];
        sgn_b    = ~bus.op[0] & bus.b[WIDTH-1];
        mag_a    = sgn_a ? -bus.a : bus.a;
        mag_b    = sgn_b ? -bus.b : bus.b;
        addend   = '0;
        sum      = '0;
        trial    = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op[1] && (bus.b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        // dvsr holds the multiplicand or divisor; acc low half the multiplier or dividend
                        state_d  = CALC;
                        cnt_d    = CNT_W'(WIDTH);
                        is_div_d = bus.op[1];
                        neg_lo_d = sgn_a ^ sgn_b;
                        neg_hi_d = sgn_a;
                        dvsr_d   = bus.op[1] ? mag_b : mag_a;
                        acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // borrow out of the WIDTH+1 bit trial means the divisor did not fit
                    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr_q};
                    if (!trial[WIDTH]) begin
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    addend = acc_q[0] ? {1'b0, dvsr_q} : '0;
                    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
                    acc_d  = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule
